omap_biu: RTL and testbench
===========================

OMAP_BIU -- requirements
Module: omap_biu

Interface
REQ-001 clk  input  1  sole clock; all logic on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 omap_start  input  1  one-cycle pulse; starts one output-map write-back job.
REQ-004 omap_done  output  1  one-cycle pulse when the job completes.
REQ-005 out_ch  input  8  output channel count; multiple of 4; sampled at omap_start.
REQ-006 map_size  input  16  pixels per channel plane; sampled at omap_start.
REQ-007 omap_base_addr  input  32  byte address of the first word; word aligned; sampled at omap_start.
REQ-008 mac2omap_data  input  32  result word from the MAC array: 4 packed int8 channels.
REQ-009 mac2omap_vld  input  1  mac2omap_data is valid.
REQ-010 mac2omap_rdy  output  1  block accepts the word this cycle.
REQ-011 omap_biu2arb_addr  output  32  write request byte address.
REQ-012 omap_biu2arb_data  output  32  write request data.
REQ-013 omap_biu2arb_vld  output  1  write request valid.
REQ-014 omap_biu2arb_rdy  input  1  arbiter accepts the request.
REQ-015 arb2omap_biu_bvld  input  1  write-complete response from the arbiter.
REQ-016 arb2omap_biu_brdy  output  1  response accept; tied high while BUSY or DRAIN, low otherwise.

Function
REQ-017 Job word count N = map_size * (out_ch >> 2), 22 bits, latched at omap_start.
- out_ch[1:0] is ignored.
REQ-018 FSM states and transitions:
- IDLE -> BUSY on omap_start.
- BUSY -> DRAIN when N words have been accepted from the MAC array.
- DRAIN -> DONE when N write requests have been issued and N responses received.
- DONE -> IDLE after one cycle; omap_done = 1 only in DONE.
REQ-019 omap_start is ignored outside IDLE.
- If N = 0: BUSY -> DRAIN -> DONE with no transfers, so omap_done rises exactly 3 cycles after the start pulse.
REQ-020 mac2omap_rdy = 1 only when all of these hold: state is BUSY, the internal FIFO is not full, and fewer than N words have been accepted.
- A word transfers when vld and rdy are both high.
REQ-021 Accepted words enter a 4-entry FIFO.
- The FIFO head drives omap_biu2arb_data combinationally.
- omap_biu2arb_vld = FIFO not empty AND outstanding count < 8.
REQ-022 Write address for word k (0-based, issue order) = omap_base_addr + 4*k, modulo 2^32.
- Address wraps silently past 0xFFFF_FFFC.
REQ-023 A request transfers when vld and rdy are both high; the FIFO pops on that cycle.
- addr, data and vld hold stable while vld=1 and rdy=0.
REQ-024 Outstanding counter (4 bits):
- +1 per issued request, -1 per bvld.
- Simultaneous issue and response leave it unchanged.
- A bvld with zero outstanding is ignored.
REQ-025 FIFO push and pop in the same cycle are both allowed when the FIFO is full or empty:
- full: the pop frees the slot;
- empty: data bypasses via the registered slot, no combinational path from mac2omap to arbiter.
REQ-026 Zero-bubble throughput: one word per cycle when rdy and bvld keep up.

Reset
REQ-027 During rst, the following are cleared:
- state = IDLE;
- FIFO empty;
- all counters = 0;
- omap_done = 0, mac2omap_rdy = 0, omap_biu2arb_vld = 0, arb2omap_biu_brdy = 0;
- omap_biu2arb_addr = 0, omap_biu2arb_data = 0.
REQ-028 rst mid-job abandons the job:
- no omap_done is produced;
- responses to already-issued requests arriving after reset are ignored.

Structure
REQ-029 Shared package acc_pkg holds:
- FIFO depth (4), max outstanding (8), FSM state encoding;
- ADDR_W = 32, DATA_W = 32, CNT_W = 22.
REQ-030 The FIFO is sub-module omap_fifo (sync, parameterized depth/width, full/empty outputs).
- FSM, counters and address generation stay in omap_biu.

Verification
REQ-031 Basic job:
- Stimulus: out_ch=8, map_size=4, base=0x1000; MAC vld always 1; rdy and bvld 1 cycle after each request.
- Required response: 8 writes at 0x1000..0x101C with matching data, in order; omap_done once.
REQ-032 Backpressure:
- Stimulus: omap_biu2arb_rdy low for 10 cycles mid-job.
- Required response: FIFO fills, mac2omap_rdy drops after 4 words, addr/data stable, no word lost or duplicated.
REQ-033 Outstanding limit:
- Stimulus: bvld withheld.
- Required response: exactly 8 requests issued, then vld=0 until a response arrives.
REQ-034 Zero size:
- Stimulus: map_size=0.
- Required response: no requests; omap_done 3 cycles after start; second start during BUSY ignored.
REQ-035 Wrap:
- Stimulus: base=0xFFFF_FFF8, N=4.
- Required response: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-036 Reset mid-job:
- Stimulus: rst asserted after 3 of 8 writes.
- Required response: all outputs at reset values next cycle; no omap_done; a new job then runs cleanly.

Source files
------------

// File: rtl/acc_pkg.sv
// acc_pkg: shared widths, limits and FSM encoding for the accelerator write-back path
package acc_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W = 22;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_OUTST = 8;
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;
endpackage

// File: rtl/omap_fifo.sv
// omap_fifo: synchronous FIFO with registered storage and full/empty flags
module omap_fifo
  import acc_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= wp == AW'(DEPTH-1) ? '0 : wp + 1'b1;
      end
      if (do_pop) rp <= rp == AW'(DEPTH-1) ? '0 : rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/omap_biu.sv
// omap_biu: streams MAC result words into posted writes with bounded outstanding responses
module omap_biu
  import acc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              omap_start,
  output logic              omap_done,
  input  logic [7:0]        out_ch,
  input  logic [15:0]       map_size,
  input  logic [ADDR_W-1:0] omap_base_addr,
  input  logic [DATA_W-1:0] mac2omap_data,
  input  logic              mac2omap_vld,
  output logic              mac2omap_rdy,
  output logic [ADDR_W-1:0] omap_biu2arb_addr,
  output logic [DATA_W-1:0] omap_biu2arb_data,
  output logic              omap_biu2arb_vld,
  input  logic              omap_biu2arb_rdy,
  input  logic              arb2omap_biu_bvld,
  output logic              arb2omap_biu_brdy
);
  state_t state;
  logic [CNT_W-1:0] n_words, acc_cnt, iss_cnt, rsp_cnt;
  logic [ADDR_W-1:0] base;
  logic [3:0] outst;
  logic full, empty, push, issue, resp;
  logic unused_ch;
  assign unused_ch = ^out_ch[1:0];
  assign mac2omap_rdy = state == BUSY && !full && acc_cnt < n_words;
  assign push = mac2omap_vld && mac2omap_rdy;
  assign omap_biu2arb_vld = !empty && outst < 4'(MAX_OUTST);
  assign issue = omap_biu2arb_vld && omap_biu2arb_rdy;
  assign arb2omap_biu_brdy = state == BUSY || state == DRAIN;
  // responses with nothing outstanding (e.g. stale ones after reset) are dropped
  assign resp = arb2omap_biu_bvld && arb2omap_biu_brdy && outst != '0;
  assign omap_biu2arb_addr = base + ADDR_W'({iss_cnt, 2'b00});
  assign omap_done = state == DONE;
  omap_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(mac2omap_data), .pop(issue),
    .dout(omap_biu2arb_data), .full(full), .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n_words <= '0;
      acc_cnt <= '0;
      iss_cnt <= '0;
      rsp_cnt <= '0;
      base <= '0;
      outst <= '0;
    end else begin
      if (push) acc_cnt <= acc_cnt + 1'b1;
      if (issue) iss_cnt <= iss_cnt + 1'b1;
      if (resp) rsp_cnt <= rsp_cnt + 1'b1;
      outst <= outst + 4'(issue) - 4'(resp);
      if (state == IDLE && omap_start) begin
        n_words <= CNT_W'(map_size) * CNT_W'(out_ch[7:2]);
        base <= omap_base_addr;
        acc_cnt <= '0;
        iss_cnt <= '0;
        rsp_cnt <= '0;
        state <= BUSY;
      end else if (state == BUSY && acc_cnt == n_words) state <= DRAIN;
      else if (state == DRAIN && iss_cnt == n_words && rsp_cnt == n_words) state <= DONE;
      else if (state == DONE) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_omap_biu.sv
// tb_omap_biu: directed checks of write-back ordering, backpressure, limits, wrap and reset
module tb_omap_biu;
  logic clk = 0, rst, omap_start, omap_done;
  logic [7:0] out_ch;
  logic [15:0] map_size;
  logic [31:0] omap_base_addr, mac2omap_data, omap_biu2arb_addr, omap_biu2arb_data;
  logic mac2omap_vld, mac2omap_rdy, omap_biu2arb_vld, omap_biu2arb_rdy;
  logic arb2omap_biu_bvld, arb2omap_biu_brdy;
  int n_chk = 0, n_fail = 0;
  int iss, acc, done_cnt, done_at, tick_no, resp_q = 0, stall = 0, stall_at = -1;
  bit withhold = 0, job_on = 0, hold_ok = 0;
  logic [7:0] seed_e;
  logic [31:0] base_e, hold_addr, hold_data;
  logic [31:0] addr_log [16];

  omap_biu dut (
    .clk(clk), .rst(rst), .omap_start(omap_start), .omap_done(omap_done),
    .out_ch(out_ch), .map_size(map_size), .omap_base_addr(omap_base_addr),
    .mac2omap_data(mac2omap_data), .mac2omap_vld(mac2omap_vld), .mac2omap_rdy(mac2omap_rdy),
    .omap_biu2arb_addr(omap_biu2arb_addr), .omap_biu2arb_data(omap_biu2arb_data),
    .omap_biu2arb_vld(omap_biu2arb_vld), .omap_biu2arb_rdy(omap_biu2arb_rdy),
    .arb2omap_biu_bvld(arb2omap_biu_bvld), .arb2omap_biu_brdy(arb2omap_biu_brdy)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(logic [7:0] s, int k);
    logic [7:0] kb;
    kb = 8'(k);
    return {s, kb, ~kb, 8'h5A};
  endfunction

  task automatic tick();
    omap_biu2arb_rdy = !rst && stall == 0;
    if (stall == 1) begin
      check("stall_mac_rdy", {31'b0, mac2omap_rdy}, 0);
      check("stall_fifo_fill", acc - iss, 4);
    end
    if (stall > 0) stall--;
    arb2omap_biu_bvld = resp_q > 0 && !withhold;
    if (arb2omap_biu_bvld) resp_q--;
    mac2omap_vld = job_on && !rst;
    mac2omap_data = word(seed_e, acc);
    if (!omap_biu2arb_rdy && !rst && omap_biu2arb_vld) begin
      if (hold_ok) begin
        check("hold_addr", omap_biu2arb_addr, hold_addr);
        check("hold_data", omap_biu2arb_data, hold_data);
      end
      hold_ok = 1;
      hold_addr = omap_biu2arb_addr;
      hold_data = omap_biu2arb_data;
    end else hold_ok = 0;
    if (omap_biu2arb_vld && omap_biu2arb_rdy) begin
      check("wr_addr", omap_biu2arb_addr, base_e + 32'(4 * iss));
      check("wr_data", omap_biu2arb_data, word(seed_e, iss));
      if (iss < 16) addr_log[iss] = omap_biu2arb_addr;
      iss++;
      resp_q++;
      if (iss == stall_at) stall = 10;
    end
    if (mac2omap_vld && mac2omap_rdy) acc++;
    @(posedge clk);
    @(negedge clk);
    tick_no++;
    if (omap_done) begin
      done_cnt++;
      if (done_at < 0) done_at = tick_no;
    end
  endtask

  task automatic start_job(logic [7:0] oc, logic [15:0] ms, logic [31:0] b, logic [7:0] s);
    out_ch = oc;
    map_size = ms;
    omap_base_addr = b;
    base_e = b;
    seed_e = s;
    iss = 0;
    acc = 0;
    done_cnt = 0;
    done_at = -1;
    tick_no = 0;
    job_on = 1;
    omap_start = 1;
    tick();
    omap_start = 0;
  endtask

  task automatic wait_done(int n, int budget);
    int c = 0;
    while (done_cnt == 0 && c < budget) begin
      tick();
      c++;
    end
    check("done_seen", {31'b0, done_cnt != 0}, 1);
    repeat (4) tick();
    job_on = 0;
    check("write_count", iss, n);
    check("done_once", done_cnt, 1);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_done"}, {31'b0, omap_done}, 0);
    check({tag, "_mac_rdy"}, {31'b0, mac2omap_rdy}, 0);
    check({tag, "_vld"}, {31'b0, omap_biu2arb_vld}, 0);
    check({tag, "_brdy"}, {31'b0, arb2omap_biu_brdy}, 0);
    check({tag, "_addr"}, omap_biu2arb_addr, 0);
    check({tag, "_data"}, omap_biu2arb_data, 0);
  endtask

  initial begin
    int c;
    rst = 1;
    omap_start = 0;
    out_ch = 0;
    map_size = 0;
    omap_base_addr = 0;
    seed_e = 0;
    base_e = 0;
    @(negedge clk);
    repeat (2) tick();
    check_reset_outputs("reset");
    rst = 0;
    tick();

    start_job(8'd8, 16'd4, 32'h0000_1000, 8'h11);
    wait_done(8, 100);
    check("basic_last_addr", addr_log[7], 32'h0000_101C);

    stall_at = 2;
    start_job(8'd8, 16'd4, 32'h0000_2000, 8'h22);
    wait_done(8, 100);
    stall_at = -1;

    start_job(8'd16, 16'd4, 32'h0000_8000, 8'h33);
    withhold = 1;
    repeat (30) tick();
    check("limit_issued", iss, 8);
    check("limit_vld", {31'b0, omap_biu2arb_vld}, 0);
    withhold = 0;
    wait_done(16, 200);

    start_job(8'd8, 16'd0, 32'h0000_5000, 8'h77);
    omap_start = 1;
    tick();
    omap_start = 0;
    repeat (8) tick();
    job_on = 0;
    check("zero_done_at", done_at, 3);
    check("zero_done_once", done_cnt, 1);
    check("zero_writes", iss, 0);

    start_job(8'd4, 16'd4, 32'hFFFF_FFF8, 8'h44);
    wait_done(4, 100);
    check("wrap_a0", addr_log[0], 32'hFFFF_FFF8);
    check("wrap_a1", addr_log[1], 32'hFFFF_FFFC);
    check("wrap_a2", addr_log[2], 32'h0000_0000);
    check("wrap_a3", addr_log[3], 32'h0000_0004);

    start_job(8'd8, 16'd4, 32'h0000_3000, 8'h55);
    c = 0;
    while (iss < 3 && c < 50) begin
      tick();
      c++;
    end
    check("rst_pre_issued", iss, 3);
    rst = 1;
    tick();
    check_reset_outputs("midrst");
    rst = 0;
    job_on = 0;
    repeat (6) tick();
    check("midrst_no_done", done_cnt, 0);
    start_job(8'd8, 16'd4, 32'h0000_4000, 8'h66);
    wait_done(8, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
